// File: rtl/ker_clk_switch_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : ker_clk_switch_ctrl
// Brief    : Kernel clock source change sequencer. On a new select it
//            requests the new oscillator, waits for it to be ready,
//            gates the kernel clock off, switches the mux select, lets
//            the mux settle and ungates, keeping per_ker_clks glitch-free.
// Options  : KER_CLK_SW_TIMEOUT_EN - bound the oscillator-ready wait to
//            TIMEOUT_CYCLES and flag sw_err when it expires.
// Revision : 1.0 - initial release
// =====================================================================
module ker_clk_switch_ctrl #(
  parameter int KER_CLK_SRC_NUM   = 5,
  parameter int SEL_W             = ($clog2(KER_CLK_SRC_NUM) > 1) ? $clog2(KER_CLK_SRC_NUM) : 1,
  parameter int RST_SEL           = 0,
  parameter int GATE_OFF_CYCLES   = 2,
  parameter int MUX_SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                       i_clk,
  input  logic                       sys_rst,
  input  logic                       sel_req_valid,
  input  logic [SEL_W-1:0]           sel_req,
  output logic                       sel_req_ready,
  input  logic [KER_CLK_SRC_NUM-1:0] src_rdy,
  output logic [KER_CLK_SRC_NUM-1:0] src_on_req,
  output logic [SEL_W-1:0]           ker_clk_sel,
  output logic                       ker_clk_gate_en,
  output logic                       busy,
  output logic                       sw_done,
  output logic                       sw_err,
  input  logic                       err_clr
);

  localparam int c_CNT_MAX = (GATE_OFF_CYCLES > MUX_SETTLE_CYCLES) ? GATE_OFF_CYCLES : MUX_SETTLE_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0]         c_GATE_LOAD   = c_CNT_W'(GATE_OFF_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]         c_SETTLE_LOAD = c_CNT_W'(MUX_SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]             c_SRC_NUM     = (SEL_W + 1)'(KER_CLK_SRC_NUM);
  localparam logic [KER_CLK_SRC_NUM-1:0] c_ONE         = KER_CLK_SRC_NUM'(1);
  localparam logic [SEL_W-1:0]           c_RST_SEL     = SEL_W'(RST_SEL);
  localparam logic [KER_CLK_SRC_NUM-1:0] c_RST_ONEHOT  = c_ONE << c_RST_SEL;

  // Zero-length phases would skip the gate-off or settle window entirely.
  if ((GATE_OFF_CYCLES < 1) || (MUX_SETTLE_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("ker_clk_switch_ctrl: cycle-count parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SRC_WAIT = 2'd1,
    S_GATE_OFF = 2'd2,
    S_SWITCH   = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [SEL_W-1:0]           new_sel_q, new_sel_d;
  logic [SEL_W-1:0]           old_sel_q, old_sel_d;
  logic                       gate_q, gate_d;
  logic [KER_CLK_SRC_NUM-1:0] on_q, on_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [c_CNT_W-1:0]         cnt_q, cnt_d;

`ifdef KER_CLK_SW_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;

  // Oscillator-ready wait counter, restarted on every accepted switch.
  always_ff @(posedge i_clk) begin
    if (sys_rst) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
`endif

  // Next-state and registered-output decode for the switch sequence.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    new_sel_d = new_sel_q;
    old_sel_d = old_sel_q;
    gate_d    = gate_q;
    on_d      = on_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    // Clear first so that any set event below overrides a same-cycle clear.
    err_d     = err_clr ? 1'b0 : err_q;
`ifdef KER_CLK_SW_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_req_valid && ready_q) begin
          if ({1'b0, sel_req} >= c_SRC_NUM) begin
            err_d = 1'b1;
          end else if (sel_req == sel_q) begin
            done_d = 1'b1;
          end else begin
            new_sel_d = sel_req;
            old_sel_d = sel_q;
            // Old source stays requested until the mux has left it.
            on_d      = on_q | (c_ONE << sel_req);
            state_d   = S_SRC_WAIT;
`ifdef KER_CLK_SW_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
          end
        end
      end
      S_SRC_WAIT: begin
        if (src_rdy[new_sel_q]) begin
          gate_d  = 1'b0;
          cnt_d   = c_GATE_LOAD;
          state_d = S_GATE_OFF;
        end
`ifdef KER_CLK_SW_TIMEOUT_EN
        else if (to_cnt_q == c_TO_LAST) begin
          // Abandon the switch: drop the new request, keep the old clock running.
          on_d    = on_q & ~(c_ONE << new_sel_q);
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + c_TO_W'(1);
        end
`endif
      end
      S_GATE_OFF: begin
        if (cnt_q == '0) begin
          sel_d   = new_sel_q;
          cnt_d   = c_SETTLE_LOAD;
          state_d = S_SWITCH;
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      S_SWITCH: begin
        if (cnt_q == '0) begin
          gate_d  = 1'b1;
          done_d  = 1'b1;
          on_d    = on_q & ~(c_ONE << old_sel_q);
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any partial switch.
  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      sel_q     <= c_RST_SEL;
      new_sel_q <= c_RST_SEL;
      old_sel_q <= c_RST_SEL;
      gate_q    <= 1'b1;
      on_q      <= c_RST_ONEHOT;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      new_sel_q <= new_sel_d;
      old_sel_q <= old_sel_d;
      gate_q    <= gate_d;
      on_q      <= on_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel_req_ready   = ready_q;
  assign src_on_req      = on_q;
  assign ker_clk_sel     = sel_q;
  assign ker_clk_gate_en = gate_q;
  assign busy            = busy_q;
  assign sw_done         = done_q;
  assign sw_err          = err_q;

endmodule

`default_nettype wire
